// File: rtl/battousai_mem_ctrl_if.sv
// Data-memory bus between the access sequencer (master) and the 64-bit data memory (slave).
interface battousai_mem_ctrl_if;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/battousai_mem_ctrl.sv
// Data-memory access sequencer for the multicycle RV64 datapath: loads, sd writes and
// sub-doubleword read-modify-write stores, with misalignment rejection.
module battousai_mem_ctrl #(
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          instr,
    input  logic [63:0]          addr,
    input  logic [63:0]          store_data,
    output logic [63:0]          load_data,
    output logic                 busy,
    output logic                 done,
    output logic                 misalign_err,
    battousai_mem_ctrl_if.master mem
);
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 2);

    typedef enum logic [2:0] {IDLE, READ, WAIT, MERGE, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        is_load_q;
    logic        err_q;
    logic [2:0]  funct3_q;
    logic [2:0]  off_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [2:0]  off;
    logic        align_bad;
    logic        misaligned;
    logic [5:0]  shamt;
    logic [63:0] base_mask;
    logic [63:0] byte_mask;
    logic [63:0] merged;
    logic        unused_ok;

    assign unused_ok = &{1'b0, instr[31:15], instr[11:7]};

    // Decode of the incoming request; only memory opcodes can be misaligned.
    always_comb begin
        opcode    = instr[6:0];
        funct3    = instr[14:12];
        off       = addr[2:0];
        align_bad = 1'b0;
        case (funct3)
            3'd1, 3'd5: align_bad = off[0];
            3'd2, 3'd6: align_bad = |off[1:0];
            3'd3:       align_bad = |off;
            default:    align_bad = 1'b0;
        endcase
        misaligned = align_bad && ((opcode == OP_LOAD) || (opcode == OP_STORE));
    end

    always_comb begin
        shamt     = {off_q, 3'b000};
        base_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (funct3_q)
            3'd0:    base_mask = 64'h0000_0000_0000_00FF;
            3'd1:    base_mask = 64'h0000_0000_0000_FFFF;
            3'd2:    base_mask = 64'h0000_0000_FFFF_FFFF;
            default: base_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        byte_mask = base_mask << shamt;
        merged    = (mem.mem_rdata & ~byte_mask) | ((wdata_q << shamt) & byte_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes decode the registered state, so start never reaches them combinationally.
    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        done         = (state == DONE);
        misalign_err = (state == DONE) && err_q;
        mem.mem_rd   = (state == READ);
        mem.mem_wr   = (state == WRITE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        state_nxt = DONE;
                    end else if (opcode == OP_LOAD) begin
                        state_nxt = READ;
                    end else if ((opcode == OP_STORE) && (funct3 == 3'd3)) begin
                        state_nxt = WRITE;
                    end else if ((opcode == OP_STORE) && (funct3 < 3'd3)) begin
                        state_nxt = READ;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            READ:    state_nxt = (MEM_LATENCY > 1) ? WAIT : MERGE;
            WAIT:    state_nxt = (wait_cnt == WAIT_LAST) ? MERGE : WAIT;
            MERGE:   state_nxt = is_load_q ? DONE : WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // wdata_q carries store_data from start; the RMW path overwrites it with the merged word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= 4'd0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
            funct3_q  <= 3'd0;
            off_q     <= 3'd0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            load_data <= 64'd0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if ((state == IDLE) && start) begin
                is_load_q <= (opcode == OP_LOAD);
                err_q     <= misaligned;
                funct3_q  <= funct3;
                off_q     <= off;
                addr_q    <= {addr[63:3], 3'b000};
                wdata_q   <= store_data;
            end
            if (state == MERGE) begin
                if (is_load_q) begin
                    load_data <= mem.mem_rdata >> shamt;
                end else begin
                    wdata_q <= merged;
                end
            end
        end
    end
endmodule

// File: tb/tb_battousai_mem_ctrl.sv
// Directed bench for battousai_mem_ctrl: vector table plus hand sequences for held start,
// reset during WAIT and a MEM_LATENCY=1 instance.
module tb_battousai_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start2 = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] store_data = 64'd0;
    logic [63:0] load2, load1;
    logic        busy2, busy1, done2, done1, err2, err1;

    int checks = 0;
    int errors = 0;

    battousai_mem_ctrl_if m2();
    battousai_mem_ctrl_if m1();

    always #5 clk = ~clk;

    battousai_mem_ctrl #(.MEM_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .instr(instr), .addr(addr),
        .store_data(store_data), .load_data(load2), .busy(busy2), .done(done2),
        .misalign_err(err2), .mem(m2.master)
    );

    battousai_mem_ctrl #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .instr(instr), .addr(addr),
        .store_data(store_data), .load_data(load1), .busy(busy1), .done(done1),
        .misalign_err(err1), .mem(m1.master)
    );

    // Memory models: unwritten words read as 0x8877665544332211; data valid only L cycles after mem_rd.
    localparam logic [63:0] DEFAULT_WORD = 64'h8877_6655_4433_2211;
    logic [63:0] mem2 [256];
    logic [63:0] mem1 [256];
    bit          wr2 [256];
    bit          wr1 [256];
    logic [3:0]  cnt2 = 4'd0;
    logic [3:0]  cnt1 = 4'd0;
    logic [7:0]  ra2 = 8'd0;
    logic [7:0]  ra1 = 8'd0;

    always @(posedge clk) begin
        if (m2.mem_rd) begin
            cnt2 <= 4'd2;
            ra2  <= m2.mem_addr[10:3];
        end else if (cnt2 != 4'd0) begin
            cnt2 <= cnt2 - 4'd1;
        end
        if (m2.mem_wr) begin
            mem2[m2.mem_addr[10:3]] <= m2.mem_wdata;
            wr2[m2.mem_addr[10:3]]  <= 1'b1;
        end
        if (m1.mem_rd) begin
            cnt1 <= 4'd1;
            ra1  <= m1.mem_addr[10:3];
        end else if (cnt1 != 4'd0) begin
            cnt1 <= cnt1 - 4'd1;
        end
        if (m1.mem_wr) begin
            mem1[m1.mem_addr[10:3]] <= m1.mem_wdata;
            wr1[m1.mem_addr[10:3]]  <= 1'b1;
        end
    end

    assign m2.mem_rdata = (cnt2 != 4'd1) ? 64'hDEAD_BEEF_0BAD_F00D :
                          (wr2[ra2] ? mem2[ra2] : DEFAULT_WORD);
    assign m1.mem_rdata = (cnt1 != 4'd1) ? 64'hDEAD_BEEF_0BAD_F00D :
                          (wr1[ra1] ? mem1[ra1] : DEFAULT_WORD);

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] addr;
        logic [63:0] sdata;
        int          exp_done;
        int          exp_rd;
        int          exp_wr;
        logic        exp_err;
        logic [63:0] exp_load;
        logic [63:0] exp_wdata;
        logic [63:0] exp_maddr;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [31:0] i, input logic [63:0] a,
                                 input logic [63:0] d);
        @(negedge clk);
        instr      = i;
        addr       = a;
        store_data = d;
        if (sel) start1 = 1'b1;
        else     start2 = 1'b1;
    endtask

    task automatic sampleDut(input bit sel, output logic rd, output logic wr, output logic dn,
                             output logic er, output logic bs, output logic [63:0] ld,
                             output logic [63:0] ma, output logic [63:0] wd);
        if (sel) begin
            rd = m1.mem_rd; wr = m1.mem_wr; dn = done1; er = err1; bs = busy1;
            ld = load1; ma = m1.mem_addr; wd = m1.mem_wdata;
        end else begin
            rd = m2.mem_rd; wr = m2.mem_wr; dn = done2; er = err2; bs = busy2;
            ld = load2; ma = m2.mem_addr; wd = m2.mem_wdata;
        end
    endtask

    task automatic runVector(input vec_t v, input bit sel);
        int          rd_cyc = 0, rd_n = 0, wr_cyc = 0, done_cyc = 0, clash = 0;
        logic        busy_c1 = 1'b0, er_d = 1'b0;
        logic [63:0] wd_w = '0, ma_w = '0, ld_d = '0, ma_d = '0;
        logic        rd, wr, dn, er, bs;
        logic [63:0] ld, ma, wd;
        applyStimulus(sel, v.instr, v.addr, v.sdata);
        @(posedge clk);
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start1 = 1'b0;
                start2 = 1'b0;
            end
            sampleDut(sel, rd, wr, dn, er, bs, ld, ma, wd);
            if (c == 1) busy_c1 = bs;
            if (rd) begin
                rd_n++;
                if (rd_cyc == 0) rd_cyc = c;
            end
            if (wr && wr_cyc == 0) begin
                wr_cyc = c;
                wd_w   = wd;
                ma_w   = ma;
            end
            if (rd && wr) clash++;
            if (dn) begin
                done_cyc = c;
                er_d     = er;
                ld_d     = ld;
                ma_d     = ma;
            end
        end
        checkOutput({v.name, " done cycle"}, 64'(done_cyc), 64'(v.exp_done));
        checkOutput({v.name, " misalign_err"}, {63'd0, er_d}, {63'd0, v.exp_err});
        checkOutput({v.name, " mem_rd cycle"}, 64'(rd_cyc), 64'(v.exp_rd));
        checkOutput({v.name, " mem_rd count"}, 64'(rd_n), (v.exp_rd != 0) ? 64'd1 : 64'd0);
        checkOutput({v.name, " mem_wr cycle"}, 64'(wr_cyc), 64'(v.exp_wr));
        checkOutput({v.name, " rd/wr overlap"}, 64'(clash), 64'd0);
        checkOutput({v.name, " busy cycle 1"}, {63'd0, busy_c1}, 64'd1);
        checkOutput({v.name, " load_data"}, ld_d, v.exp_load);
        checkOutput({v.name, " mem_addr"}, ma_d, v.exp_maddr);
        if (v.exp_wr != 0) begin
            checkOutput({v.name, " mem_wdata"}, wd_w, v.exp_wdata);
            checkOutput({v.name, " write addr"}, ma_w, v.exp_maddr);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          rd_n, done_a, done_b, ndone;
        logic        rd6, busy5;
        vec_t        v1;

        vecs[0]  = '{"lb 0x103", mk(7'd3, 3'd0), 64'h103, 64'h0, 4, 1, 0, 1'b0,
                     64'h0000_0088_7766_5544, 64'h0, 64'h100};
        vecs[1]  = '{"sb 0x102", mk(7'd35, 3'd0), 64'h102, 64'hAB, 5, 1, 4, 1'b0,
                     64'h0000_0088_7766_5544, 64'h8877_6655_44AB_2211, 64'h100};
        vecs[2]  = '{"lb 0x102", mk(7'd3, 3'd0), 64'h102, 64'h0, 4, 1, 0, 1'b0,
                     64'h0000_8877_6655_44AB, 64'h0, 64'h100};
        vecs[3]  = '{"sd 0x108", mk(7'd35, 3'd3), 64'h108, 64'hDEAD_BEEF_CAFE_F00D, 2, 0, 1, 1'b0,
                     64'h0000_8877_6655_44AB, 64'hDEAD_BEEF_CAFE_F00D, 64'h108};
        vecs[4]  = '{"ld 0x108", mk(7'd3, 3'd3), 64'h108, 64'h0, 4, 1, 0, 1'b0,
                     64'hDEAD_BEEF_CAFE_F00D, 64'h0, 64'h108};
        vecs[5]  = '{"sh 0x10A", mk(7'd35, 3'd1), 64'h10A, 64'hFFFF_FFFF_FFFF_1234, 5, 1, 4, 1'b0,
                     64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_1234_F00D, 64'h108};
        vecs[6]  = '{"sw 0x10C", mk(7'd35, 3'd2), 64'h10C, 64'hAAAA_AAAA_5566_7788, 5, 1, 4, 1'b0,
                     64'hDEAD_BEEF_CAFE_F00D, 64'h5566_7788_1234_F00D, 64'h108};
        vecs[7]  = '{"lw 0x104", mk(7'd3, 3'd2), 64'h104, 64'h0, 4, 1, 0, 1'b0,
                     64'h0000_0000_8877_6655, 64'h0, 64'h100};
        vecs[8]  = '{"sh 0x101 misaligned", mk(7'd35, 3'd1), 64'h101, 64'h5555, 1, 0, 0, 1'b1,
                     64'h0000_0000_8877_6655, 64'h0, 64'h100};
        vecs[9]  = '{"lw 0x106 misaligned", mk(7'd3, 3'd2), 64'h106, 64'h0, 1, 0, 0, 1'b1,
                     64'h0000_0000_8877_6655, 64'h0, 64'h100};
        vecs[10] = '{"opcode 51", mk(7'd51, 3'd0), 64'h200, 64'h0, 1, 0, 0, 1'b0,
                     64'h0000_0000_8877_6655, 64'h0, 64'h200};
        vecs[11] = '{"sd 0x10C misaligned", mk(7'd35, 3'd3), 64'h10C, 64'h1, 1, 0, 0, 1'b1,
                     64'h0000_0000_8877_6655, 64'h0, 64'h108};
        vecs[12] = '{"lbu 0x107", mk(7'd3, 3'd4), 64'h107, 64'h0, 4, 1, 0, 1'b0,
                     64'h0000_0000_0000_0088, 64'h0, 64'h100};

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", {62'd0, busy2, busy1}, 64'd0);
        checkOutput("reset done", {62'd0, done2, done1}, 64'd0);
        checkOutput("reset misalign_err", {62'd0, err2, err1}, 64'd0);
        checkOutput("reset strobes", {60'd0, m2.mem_rd, m2.mem_wr, m1.mem_rd, m1.mem_wr}, 64'd0);
        checkOutput("reset load_data", load2 | load1, 64'd0);
        checkOutput("reset mem_addr", m2.mem_addr | m1.mem_addr, 64'd0);
        checkOutput("reset mem_wdata", m2.mem_wdata | m1.mem_wdata, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            runVector(vecs[i], 1'b0);
        end

        // start held high through a whole load: one access, the next only after DONE.
        applyStimulus(1'b0, mk(7'd3, 3'd0), 64'h100, 64'h0);
        @(posedge clk);
        rd_n = 0; done_a = 0; done_b = 0; rd6 = 1'b0; busy5 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (m2.mem_rd && c <= 5) rd_n++;
            if (c == 5) busy5 = busy2;
            if (c == 6) begin
                rd6    = m2.mem_rd;
                start2 = 1'b0;
            end
            if (done2) begin
                if (done_a == 0) done_a = c;
                else if (done_b == 0) done_b = c;
            end
        end
        checkOutput("held start reads before idle", 64'(rd_n), 64'd1);
        checkOutput("held start first done", 64'(done_a), 64'd4);
        checkOutput("held start idle cycle busy", {63'd0, busy5}, 64'd0);
        checkOutput("held start second read", {63'd0, rd6}, 64'd1);
        checkOutput("held start second done", 64'(done_b), 64'd9);
        checkOutput("held start load_data", load2, 64'h8877_6655_44AB_2211);

        // Reset in WAIT abandons the access immediately.
        applyStimulus(1'b0, mk(7'd3, 3'd0), 64'h103, 64'h0);
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("wait reset busy", {63'd0, busy2}, 64'd0);
        checkOutput("wait reset mem_rd/mem_wr", {62'd0, m2.mem_rd, m2.mem_wr}, 64'd0);
        checkOutput("wait reset done", {63'd0, done2}, 64'd0);
        checkOutput("wait reset load_data", load2, 64'd0);
        checkOutput("wait reset mem_addr", m2.mem_addr, 64'd0);
        checkOutput("wait reset mem_wdata", m2.mem_wdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done2 || busy2) ndone++;
        end
        checkOutput("wait reset no done", 64'(ndone), 64'd0);
        runVector(vecs[0], 1'b0);

        // Same load byte on the MEM_LATENCY=1 instance.
        v1 = vecs[0];
        v1.name     = "lb 0x103 L1";
        v1.exp_done = 3;
        runVector(v1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
